// File: rtl/ram_banked_init.sv
// rtl/ram_banked_init.sv - banked WIDTH x 2**ADDR_W RAM with a zero-fill sweep after reset and a registered read port.
module ram_banked_init #(
   parameter int WIDTH  = 16,
   parameter int ADDR_W = 9,
   parameter int BANK_W = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] adr,
   input  logic [WIDTH-1:0]  data,
   input  logic              load,
   input  logic              rd_en,
   output logic [WIDTH-1:0]  out,
   output logic              rd_valid,
   output logic              busy
);
   localparam int DEPTH  = 1 << ADDR_W;
   localparam int OFF_W  = ADDR_W - BANK_W;
   localparam int NB     = 1 << BANK_W;
   localparam int BANK_D = 1 << OFF_W;

   typedef enum logic {INIT, IDLE} state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] fill_adr_q, fill_adr_d;
   logic [WIDTH-1:0]  out_q, out_d;
   logic              rd_valid_q, rd_valid_d;

   logic              wr_en;
   logic [ADDR_W-1:0] wr_adr;
   logic [WIDTH-1:0]  wr_data;
   logic [WIDTH-1:0]  rd_word;
   logic [WIDTH-1:0]  bank_rd [NB];

   // Each bank only sees a write when the upper address bits select it.
   for (genvar b = 0; b < NB; b++) begin : g_bank
      logic [WIDTH-1:0] mem [BANK_D];

      always_ff @(posedge clk) begin
         if (wr_en && ((wr_adr >> OFF_W) == ADDR_W'(b))) begin
            mem[wr_adr[OFF_W-1:0]] <= wr_data;
         end
      end

      assign bank_rd[b] = mem[adr[OFF_W-1:0]];
   end

   always_comb begin
      rd_word = '0;
      for (int b = 0; b < NB; b++) begin
         if ((adr >> OFF_W) == ADDR_W'(b)) begin
            rd_word = bank_rd[b];
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      fill_adr_d = fill_adr_q;
      out_d      = out_q;
      rd_valid_d = 1'b0;
      wr_en      = 1'b0;
      wr_adr     = adr;
      wr_data    = data;
      if (reset) begin
         state_d    = INIT;
         fill_adr_d = '0;
         out_d      = '0;
      end else begin
         case (state_q)
            INIT: begin
               wr_en      = 1'b1;
               wr_adr     = fill_adr_q;
               wr_data    = '0;
               fill_adr_d = fill_adr_q + ADDR_W'(1);
               out_d      = '0;
               if (fill_adr_q == ADDR_W'(DEPTH - 1)) begin
                  state_d = IDLE;
               end
            end
            default: begin
               wr_en      = load;
               rd_valid_d = rd_en;
               // A single address port means a same-edge read always hits the word being written.
               if (rd_en) begin
                  out_d = load ? data : rd_word;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      state_q    <= state_d;
      fill_adr_q <= fill_adr_d;
      out_q      <= out_d;
      rd_valid_q <= rd_valid_d;
   end

   assign out      = out_q;
   assign rd_valid = rd_valid_q;
   assign busy     = (state_q == INIT);
endmodule

// File: tb/tb_ram_banked_init.sv
// tb/tb_ram_banked_init.sv - directed bench for ram_banked_init (4-bit/2-bank-bit and 9-bit/3-bank-bit builds).
module tb_ram_banked_init;
   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [3:0]  adr = '0;
   logic [15:0] data = '0;
   logic        load = 1'b0;
   logic        rd_en = 1'b0;
   logic [15:0] out;
   logic        rd_valid;
   logic        busy;

   logic        reset2 = 1'b0;
   logic [8:0]  adr2 = '0;
   logic [15:0] data2 = '0;
   logic        load2 = 1'b0;
   logic        rd_en2 = 1'b0;
   logic [15:0] out2;
   logic        rd_valid2;
   logic        busy2;

   int checks = 0;
   int errors = 0;

   ram_banked_init #(.WIDTH(16), .ADDR_W(4), .BANK_W(2)) dut (
      .clk(clk), .reset(reset), .adr(adr), .data(data), .load(load), .rd_en(rd_en),
      .out(out), .rd_valid(rd_valid), .busy(busy)
   );

   ram_banked_init #(.WIDTH(16), .ADDR_W(9), .BANK_W(3)) dut2 (
      .clk(clk), .reset(reset2), .adr(adr2), .data(data2), .load(load2), .rd_en(rd_en2),
      .out(out2), .rd_valid(rd_valid2), .busy(busy2)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   task automatic wait_sweep(input string name);
      for (int i = 0; i < 16; i++) begin
         checks++;
         if (busy !== 1'b1) begin
            errors++;
            $display("FAIL %s busy during fill edge %0d: got %b want 1", name, i, busy);
         end
         tick();
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL %s busy after 16 fill edges: got %b want 0", name, busy);
      end
   endtask

   task automatic read_check(input string name, input logic [3:0] a, input logic [15:0] exp);
      adr   = a;
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      checks++;
      if (rd_valid !== 1'b1 || out !== exp) begin
         errors++;
         $display("FAIL %s adr %0d: got valid=%b out=%h want valid=1 out=%h", name, a, rd_valid, out, exp);
      end
   endtask

   task automatic write_word(input logic [3:0] a, input logic [15:0] d);
      adr  = a;
      data = d;
      load = 1'b1;
      tick();
      load = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if (busy !== 1'b1 || rd_valid !== 1'b0 || out !== 16'h0000) begin
         errors++;
         $display("FAIL reset_state: got busy=%b valid=%b out=%h want 1 0 0000", busy, rd_valid, out);
      end
      wait_sweep("reset_sweep");
      for (int a = 0; a < 16; a++) read_check("init_zero", 4'(a), 16'h0000);
      tick();
      checks++;
      if (rd_valid !== 1'b0) begin
         errors++;
         $display("FAIL valid_pulse: got %b want 0", rd_valid);
      end
   endtask

   task automatic test_back_to_back();
      logic [3:0]  a_tab [4] = '{4'd3, 4'd15, 4'd0, 4'd1};
      logic [15:0] d_tab [4] = '{16'hBEEF, 16'h1234, 16'hFFFF, 16'h0000};
      write_word(4'd3, 16'hBEEF);
      write_word(4'd15, 16'h1234);
      write_word(4'd0, 16'hFFFF);
      rd_en = 1'b1;
      for (int i = 0; i < 4; i++) begin
         adr = a_tab[i];
         tick();
         checks++;
         if (rd_valid !== 1'b1 || out !== d_tab[i]) begin
            errors++;
            $display("FAIL b2b_read %0d: got valid=%b out=%h want 1 %h", i, rd_valid, out, d_tab[i]);
         end
      end
      rd_en = 1'b0;
      tick();
      checks++;
      if (rd_valid !== 1'b0 || out !== 16'h0000) begin
         errors++;
         $display("FAIL b2b_hold: got valid=%b out=%h want 0 0000", rd_valid, out);
      end
   endtask

   task automatic test_write_through();
      adr   = 4'd7;
      data  = 16'hA5A5;
      load  = 1'b1;
      rd_en = 1'b1;
      tick();
      load  = 1'b0;
      rd_en = 1'b0;
      checks++;
      if (rd_valid !== 1'b1 || out !== 16'hA5A5) begin
         errors++;
         $display("FAIL write_through: got valid=%b out=%h want 1 a5a5", rd_valid, out);
      end
      data = 16'h0000;
      read_check("write_through_readback", 4'd7, 16'hA5A5);
   endtask

   task automatic test_busy_ignore();
      do_reset();
      adr   = 4'd0;
      data  = 16'h5555;
      load  = 1'b1;
      rd_en = 1'b1;
      for (int i = 0; i < 15; i++) begin
         tick();
         checks++;
         if (rd_valid !== 1'b0 || out !== 16'h0000 || busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_ignore edge %0d: got valid=%b out=%h busy=%b want 0 0000 1", i, rd_valid, out, busy);
         end
      end
      load  = 1'b0;
      rd_en = 1'b0;
      tick();
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL busy_ignore_end: got busy=%b want 0", busy);
      end
      read_check("busy_ignore_read", 4'd0, 16'h0000);
   endtask

   task automatic test_reset_mid_sweep();
      for (int a = 0; a < 16; a++) write_word(4'(a), 16'h00FF);
      read_check("fill_ff", 4'd9, 16'h00FF);
      adr   = 4'd9;
      rd_en = 1'b1;
      reset = 1'b1;
      tick();
      rd_en = 1'b0;
      reset = 1'b0;
      checks++;
      if (rd_valid !== 1'b0 || out !== 16'h0000) begin
         errors++;
         $display("FAIL read_dropped: got valid=%b out=%h want 0 0000", rd_valid, out);
      end
      for (int i = 0; i < 4; i++) tick();
      do_reset();
      wait_sweep("resweep");
      for (int a = 0; a < 16; a++) read_check("resweep_zero", 4'(a), 16'h0000);
   endtask

   task automatic test_bank_isolation();
      int n;
      write_word(4'd4, 16'h1111);
      read_check("bank0", 4'd0, 16'h0000);
      read_check("bank2", 4'd8, 16'h0000);
      read_check("bank3", 4'd12, 16'h0000);
      read_check("bank1", 4'd4, 16'h1111);

      reset2 = 1'b1;
      tick();
      reset2 = 1'b0;
      n = 0;
      while (busy2 === 1'b1 && n < 600) begin
         tick();
         n++;
      end
      checks++;
      if (n != 512 || busy2 !== 1'b0) begin
         errors++;
         $display("FAIL wide_sweep_len: got %0d edges busy=%b want 512 0", n, busy2);
      end
      adr2  = 9'h1FF;
      data2 = 16'hC3C3;
      load2 = 1'b1;
      tick();
      load2  = 1'b0;
      rd_en2 = 1'b1;
      tick();
      checks++;
      if (rd_valid2 !== 1'b1 || out2 !== 16'hC3C3) begin
         errors++;
         $display("FAIL wide_1ff: got valid=%b out=%h want 1 c3c3", rd_valid2, out2);
      end
      adr2 = 9'h0FF;
      tick();
      rd_en2 = 1'b0;
      checks++;
      if (rd_valid2 !== 1'b1 || out2 !== 16'h0000) begin
         errors++;
         $display("FAIL wide_0ff: got valid=%b out=%h want 1 0000", rd_valid2, out2);
      end
   endtask

   initial begin
      tick();
      test_reset();
      test_back_to_back();
      test_write_through();
      test_busy_ignore();
      test_reset_mid_sweep();
      test_bank_isolation();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
